alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the ALU's operand and control interface: input1, input2, a 4-bit alu_control, plus branch-sense qualifiers.
- Decodes opcode/funct3/funct7 into the ALU operation encoding and selects operands (register, immediate, PC, zero).
- Registers the result for the EX stage, with stall and flush control.
- Sits between the register file/immediate generator and the 64-bit ALU.

Parameters:
- XLEN, 64, datapath width of operands and PC.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID holds a valid instruction.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- rs1_data  in  XLEN  register source 1.
- rs2_data  in  XLEN  register source 2.
- imm  in  XLEN  sign-extended immediate from the immediate generator.
- pc  in  XLEN  instruction address.
- stall  in  1  hold the EX registers.
- flush  in  1  insert a bubble.
- ex_valid  out  1  EX-stage instruction valid.
- input1  out  XLEN  ALU operand A.
- input2  out  XLEN  ALU operand B.
- alu_control  out  4  ALU operation.
- is_branch  out  1  EX instruction is a conditional branch.
- branch_on_zero  out  1  branch taken when ALU zero==1 (else taken when zero==0).
- illegal  out  1  unsupported encoding.

Behaviour:
- ALU operation encoding (fixed):
  - AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101.
  - SUB=0110, SLT=0111, SLTU=1000, SRA=1101, NOP/unrecognized=1111.
- R-type (0110011), funct3 mapping:
  - 000 → ADD if funct7=0000000, SUB if funct7=0100000.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR.
  - 101 → SRL if funct7=0000000, SRA if funct7=0100000.
  - 110 → OR, 111 → AND.
  - Any other funct7 → illegal.
  - Operands: input1=rs1_data, input2=rs2_data.
- I-ALU (0010011):
  - Same funct3 map, except 000 is always ADD (no SUB).
  - Shifts (001, 101) check only funct7[6:1] (RV64 shamt[5] lives in funct7[0]): 000000 → SLL/SRL, 010000 → SRA (101 only). Other → illegal.
  - input2 = imm for non-shifts; input2 = zero-extended imm[5:0] for shifts.
- Load (0000011), store (0100011): ADD, input1=rs1_data, input2=imm.
- Branch (1100011): input1=rs1_data, input2=rs2_data, is_branch=1.
  - 000 BEQ: SUB, branch_on_zero=1.
  - 001 BNE: SUB, branch_on_zero=0.
  - 100 BLT: SLT, 0.
  - 101 BGE: SLT, 1.
  - 110 BLTU: SLTU, 0.
  - 111 BGEU: SLTU, 1.
  - 010/011 → illegal.
- LUI (0110111): ADD, input1=0, input2=imm.
- AUIPC (0010111): ADD, input1=pc, input2=imm.
- Any other opcode → illegal, alu_control=1111, input1=rs1_data, input2=rs2_data.
- is_branch=0 and branch_on_zero=0 for all non-branch instructions.
- Registered outputs, 1-cycle latency: ID values presented before edge N appear on the outputs after edge N.
- Per-edge priority:
  - reset: async, immediate.
  - flush: ex_valid=0, outputs forced to reset values.
  - stall: all outputs hold.
  - otherwise: capture the decoded values; ex_valid=in_valid.
- flush together with stall → flush wins.
- in_valid=0 and not stalled: ex_valid=0, alu_control=ADD(0010), input1=input2=0, illegal=0, is_branch=0.
- illegal is only asserted together with ex_valid=1.
- Reset values: ex_valid=0, input1=0, input2=0, alu_control=0010, is_branch=0, branch_on_zero=0, illegal=0. Reset asserted mid-stall clears everything; the first capture happens on the first edge after deassertion.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_* 4-bit operation constants;
  - OPC_* opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC);
  - the F3_* funct3 constants.
- One combinational sub-module, alu_ctrl_decode: opcode/funct3/funct7 → alu_control, operand-select codes, is_branch, branch_on_zero, illegal.
- alu_issue_stage holds the operand muxes and the pipeline register.

Test Plan:
- R-type, funct7=0100000, funct3=000, rs1=0x30, rs2=0x20 → after 1 edge: alu_control=0110, input1=0x30, input2=0x20, ex_valid=1.
- I-type, opcode 0010011, funct3=101, funct7=0100000, imm=0x404 → alu_control=1101, input2=0x4. Same with funct7=0000001, imm=0x024 (shamt 36) → alu_control=0101, input2=0x24.
- BGEU, rs1=0xFFFFFFFFFFFFFFFF, rs2=1 → alu_control=1000, is_branch=1, branch_on_zero=1. BNE → alu_control=0110, branch_on_zero=0.
- AUIPC, pc=0x1000, imm=0x2000 → input1=0x1000, input2=0x2000, alu_control=0010. LUI → input1=0.
- Opcode 1111111 with in_valid=1 → illegal=1, alu_control=1111, ex_valid=1. R-type funct7=0000001 → illegal=1.
- Hold ADD in EX:
  - stall=1 for 3 edges while ID changes → outputs unchanged.
  - stall=1 with flush=1 → ex_valid=0, alu_control=0010.
  - Async reset asserted between edges → outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: ALU operation codes,
// RV64 opcode/funct3/funct7 encodings, operand-select codes and the decode bundle.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned SHAMT_W  = 6;

  // ALU operation encoding
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 4'b1111;

  // Major opcodes
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // funct3 for ALU ops
  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [F3_W-1:0] F3_SR      = 3'b101;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;

  // funct3 for branches
  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // funct7 qualifiers; immediate shifts only look at funct7[6:1]
  localparam logic [F7_W-1:0]   F7_BASE       = 7'b0000000;
  localparam logic [F7_W-1:0]   F7_ALT        = 7'b0100000;
  localparam logic [F7_W-2:0]   F7_SHIFT_BASE = 6'b000000;
  localparam logic [F7_W-2:0]   F7_SHIFT_ALT  = 6'b010000;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_ZERO = 2'd1,
    A_SEL_PC   = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_SEL_RS2   = 2'd0,
    B_SEL_IMM   = 2'd1,
    B_SEL_SHAMT = 2'd2
  } b_sel_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    a_sel_e              a_sel;
    b_sel_e              b_sel;
    logic                is_branch;
    logic                branch_on_zero;
    logic                illegal;
  } decode_t;

  // Plain funct3 -> ALU op map (000 read as ADD, 101 read as SRL)
  function automatic logic [ALU_OP_W-1:0] f3_alu_op(input logic [F3_W-1:0] f3);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7 into ALU op, operand selects,
// branch qualifiers and an illegal-encoding flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [F7_W-1:0]  i_funct7,
  output decode_t          o_dec_c
);

  decode_t w_dec;

  // Opcode-driven decode; any illegal encoding collapses to NOP on rs1/rs2
  always_comb begin
    w_dec.alu_op         = ALU_NOP;
    w_dec.a_sel          = A_SEL_RS1;
    w_dec.b_sel          = B_SEL_RS2;
    w_dec.is_branch      = 1'b0;
    w_dec.branch_on_zero = 1'b0;
    w_dec.illegal        = 1'b0;

    case (i_opcode)
      OPC_OP: begin
        case (i_funct3)
          F3_ADD_SUB: begin
            if (i_funct7 == F7_BASE)     w_dec.alu_op = ALU_ADD;
            else if (i_funct7 == F7_ALT) w_dec.alu_op = ALU_SUB;
            else                         w_dec.illegal = 1'b1;
          end
          F3_SR: begin
            if (i_funct7 == F7_BASE)     w_dec.alu_op = ALU_SRL;
            else if (i_funct7 == F7_ALT) w_dec.alu_op = ALU_SRA;
            else                         w_dec.illegal = 1'b1;
          end
          default: begin
            if (i_funct7 == F7_BASE) w_dec.alu_op = f3_alu_op(i_funct3);
            else                     w_dec.illegal = 1'b1;
          end
        endcase
      end

      OPC_OP_IMM: begin
        w_dec.b_sel = B_SEL_IMM;
        case (i_funct3)
          F3_SLL: begin
            w_dec.b_sel = B_SEL_SHAMT;
            if (i_funct7[F7_W-1:1] == F7_SHIFT_BASE) w_dec.alu_op = ALU_SLL;
            else                                      w_dec.illegal = 1'b1;
          end
          F3_SR: begin
            w_dec.b_sel = B_SEL_SHAMT;
            if (i_funct7[F7_W-1:1] == F7_SHIFT_BASE)     w_dec.alu_op = ALU_SRL;
            else if (i_funct7[F7_W-1:1] == F7_SHIFT_ALT) w_dec.alu_op = ALU_SRA;
            else                                          w_dec.illegal = 1'b1;
          end
          default: w_dec.alu_op = f3_alu_op(i_funct3);
        endcase
      end

      OPC_LOAD, OPC_STORE: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.b_sel  = B_SEL_IMM;
      end

      OPC_BRANCH: begin
        w_dec.is_branch = 1'b1;
        case (i_funct3)
          F3_BEQ:  begin w_dec.alu_op = ALU_SUB;  w_dec.branch_on_zero = 1'b1; end
          F3_BNE:  begin w_dec.alu_op = ALU_SUB;  w_dec.branch_on_zero = 1'b0; end
          F3_BLT:  begin w_dec.alu_op = ALU_SLT;  w_dec.branch_on_zero = 1'b0; end
          F3_BGE:  begin w_dec.alu_op = ALU_SLT;  w_dec.branch_on_zero = 1'b1; end
          F3_BLTU: begin w_dec.alu_op = ALU_SLTU; w_dec.branch_on_zero = 1'b0; end
          F3_BGEU: begin w_dec.alu_op = ALU_SLTU; w_dec.branch_on_zero = 1'b1; end
          default: w_dec.illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.a_sel  = A_SEL_ZERO;
        w_dec.b_sel  = B_SEL_IMM;
      end

      OPC_AUIPC: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.a_sel  = A_SEL_PC;
        w_dec.b_sel  = B_SEL_IMM;
      end

      default: w_dec.illegal = 1'b1;
    endcase

    if (w_dec.illegal) begin
      w_dec.alu_op         = ALU_NOP;
      w_dec.a_sel          = A_SEL_RS1;
      w_dec.b_sel          = B_SEL_RS2;
      w_dec.is_branch      = 1'b0;
      w_dec.branch_on_zero = 1'b0;
    end
  end

  assign o_dec_c = w_dec;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction, muxes ALU operands and registers
// them for EX with flush (bubble) over stall (hold) priority.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     pc,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [XLEN-1:0]     input1,
  output logic [XLEN-1:0]     input2,
  output logic [ALU_OP_W-1:0] alu_control,
  output logic                is_branch,
  output logic                branch_on_zero,
  output logic                illegal
);

  decode_t               w_dec;
  logic [XLEN-1:0]       w_op_a;
  logic [XLEN-1:0]       w_op_b;

  logic                  r_ex_valid;
  logic [XLEN-1:0]       r_input1;
  logic [XLEN-1:0]       r_input2;
  logic [ALU_OP_W-1:0]   r_alu_control;
  logic                  r_is_branch;
  logic                  r_branch_on_zero;
  logic                  r_illegal;

  alu_ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_dec_c  (w_dec)
  );

  // Operand A mux: register, zero (LUI) or PC (AUIPC)
  always_comb begin
    w_op_a = rs1_data;
    case (w_dec.a_sel)
      A_SEL_ZERO: w_op_a = '0;
      A_SEL_PC:   w_op_a = pc;
      default:    w_op_a = rs1_data;
    endcase
  end

  // Operand B mux: register, immediate or zero-extended 6-bit shift amount
  always_comb begin
    w_op_b = rs2_data;
    case (w_dec.b_sel)
      B_SEL_IMM:   w_op_b = imm;
      B_SEL_SHAMT: w_op_b = XLEN'(imm[SHAMT_W-1:0]);
      default:     w_op_b = rs2_data;
    endcase
  end

  // ID/EX register: flush clears to the idle state, stall holds, else capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid       <= 1'b0;
      r_input1         <= '0;
      r_input2         <= '0;
      r_alu_control    <= ALU_ADD;
      r_is_branch      <= 1'b0;
      r_branch_on_zero <= 1'b0;
      r_illegal        <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      r_ex_valid       <= 1'b0;
      r_input1         <= '0;
      r_input2         <= '0;
      r_alu_control    <= ALU_ADD;
      r_is_branch      <= 1'b0;
      r_branch_on_zero <= 1'b0;
      r_illegal        <= 1'b0;
    end else if (!stall) begin
      r_ex_valid       <= 1'b1;
      r_input1         <= w_op_a;
      r_input2         <= w_op_b;
      r_alu_control    <= w_dec.alu_op;
      r_is_branch      <= w_dec.is_branch;
      r_branch_on_zero <= w_dec.branch_on_zero;
      r_illegal        <= w_dec.illegal;
    end
  end

  assign ex_valid       = r_ex_valid;
  assign input1         = r_input1;
  assign input2         = r_input2;
  assign alu_control    = r_alu_control;
  assign is_branch      = r_is_branch;
  assign branch_on_zero = r_branch_on_zero;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected EX outputs are queued when an
// instruction is driven and popped after the capturing edge.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        ev;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctl;
    logic        br;
    logic        boz;
    logic        ill;
  } out_t;

  typedef struct {
    logic        v;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [63:0] pc;
    out_t        e;
  } vec_t;

  localparam out_t RST = '{ev: 1'b0, a: 64'h0, b: 64'h0, ctl: 4'b0010,
                           br: 1'b0, boz: 1'b0, ill: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] rs1_data, rs2_data, imm, pc;
  logic        stall, flush;
  logic        ex_valid;
  logic [63:0] input1, input2;
  logic [3:0]  alu_control;
  logic        is_branch, branch_on_zero, illegal;

  out_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .input1(input1), .input2(input2), .alu_control(alu_control),
    .is_branch(is_branch), .branch_on_zero(branch_on_zero), .illegal(illegal)
  );

  function automatic out_t sample();
    return '{ev: ex_valid, a: input1, b: input2, ctl: alu_control,
             br: is_branch, boz: branch_on_zero, ill: illegal};
  endfunction

  function automatic out_t mk(input logic ev, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] ctl, input logic br, input logic boz,
                              input logic ill);
    return '{ev: ev, a: a, b: b, ctl: ctl, br: br, boz: boz, ill: ill};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [63:0] r1,
                               input logic [63:0] r2, input logic [63:0] im,
                               input logic [63:0] p, input out_t e);
    vec_t x;
    x.v = v; x.opc = opc; x.f3 = f3; x.f7 = f7;
    x.rs1 = r1; x.rs2 = r2; x.imm = im; x.pc = p; x.e = e;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    in_valid = x.v; opcode = x.opc; funct3 = x.f3; funct7 = x.f7;
    rs1_data = x.rs1; rs2_data = x.rs2; imm = x.imm; pc = x.pc;
  endtask

  task automatic test_reset();
    out_t got;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(mkv(1'b1, 7'b0110011, 3'b000, 7'b0100000, 64'h30, 64'h20, 64'h0, 64'h0, RST));
    #2;
    got = sample(); n_tests++;
    if (got !== RST) begin
      $display("FAIL reset_initial: got %h expected %h", got, RST); n_fail++;
    end
    @(posedge clk); #1;
    got = sample(); n_tests++;
    if (got !== RST) begin
      $display("FAIL reset_held_over_edge: got %h expected %h", got, RST); n_fail++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    vec_t q[$];
    out_t got, exp;
    q.push_back(mkv(1, 7'b0110011, 3'b000, 7'b0100000, 64'h30, 64'h20, 0, 0,
                    mk(1, 64'h30, 64'h20, 4'b0110, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110011, 3'b000, 7'b0000000, 64'h7, 64'h9, 64'h55, 0,
                    mk(1, 64'h7, 64'h9, 4'b0010, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110011, 3'b101, 7'b0100000, 64'hF0, 64'h3, 0, 0,
                    mk(1, 64'hF0, 64'h3, 4'b1101, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110011, 3'b011, 7'b0000000, 64'h1, 64'h2, 0, 0,
                    mk(1, 64'h1, 64'h2, 4'b1000, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110011, 3'b111, 7'b0000000, 64'hA, 64'hB, 0, 0,
                    mk(1, 64'hA, 64'hB, 4'b0000, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110011, 3'b100, 7'b0000000, 64'hC, 64'hD, 0, 0,
                    mk(1, 64'hC, 64'hD, 4'b0011, 0, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]); sb.push_back(q[i].e);
      @(posedge clk); #1;
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        $display("FAIL rtype[%0d]: got %h expected %h", i, got, exp); n_fail++;
      end
    end
    // Unsupported funct7 on an R-type: flagged illegal but still valid in EX
    drive(mkv(1, 7'b0110011, 3'b000, 7'b0000001, 64'h1, 64'h2, 0, 0, RST));
    @(posedge clk); #1;
    n_tests++;
    if ({ex_valid, illegal, is_branch} !== 3'b110) begin
      $display("FAIL rtype_f7_illegal: ev/ill/br=%b%b%b expected 110",
               ex_valid, illegal, is_branch); n_fail++;
    end
  endtask

  task automatic test_itype();
    vec_t q[$];
    out_t got, exp;
    q.push_back(mkv(1, 7'b0010011, 3'b101, 7'b0100000, 64'h80, 0, 64'h404, 0,
                    mk(1, 64'h80, 64'h4, 4'b1101, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0010011, 3'b101, 7'b0000001, 64'h80, 0, 64'h024, 0,
                    mk(1, 64'h80, 64'h24, 4'b0101, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0010011, 3'b001, 7'b0000001, 64'h3, 0, 64'h03F, 0,
                    mk(1, 64'h3, 64'h3F, 4'b0100, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0010011, 3'b000, 7'b0100000, 64'h10, 0, 64'hFFFF_FFFF_FFFF_FFFB, 0,
                    mk(1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFB, 4'b0010, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0010011, 3'b010, 7'b0000000, 64'h5, 64'h99, 64'h7, 0,
                    mk(1, 64'h5, 64'h7, 4'b0111, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0000011, 3'b011, 7'b0000000, 64'h100, 64'h99, 64'h8, 0,
                    mk(1, 64'h100, 64'h8, 4'b0010, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0100011, 3'b011, 7'b0000000, 64'h200, 64'h99, 64'hFFFF_FFFF_FFFF_FFF0, 0,
                    mk(1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0010, 0, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]); sb.push_back(q[i].e);
      @(posedge clk); #1;
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        $display("FAIL itype[%0d]: got %h expected %h", i, got, exp); n_fail++;
      end
    end
    drive(mkv(1, 7'b0010011, 3'b001, 7'b0100000, 64'h1, 0, 64'h401, 0, RST));
    @(posedge clk); #1;
    n_tests++;
    if ({ex_valid, illegal} !== 2'b11) begin
      $display("FAIL itype_sll_alt_illegal: ev/ill=%b%b expected 11", ex_valid, illegal);
      n_fail++;
    end
  endtask

  task automatic test_branch_upper();
    vec_t q[$];
    out_t got, exp;
    q.push_back(mkv(1, 7'b1100011, 3'b111, 7'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h40, 0,
                    mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b1000, 1, 1, 0)));
    q.push_back(mkv(1, 7'b1100011, 3'b001, 7'b0, 64'h5, 64'h6, 64'h40, 0,
                    mk(1, 64'h5, 64'h6, 4'b0110, 1, 0, 0)));
    q.push_back(mkv(1, 7'b1100011, 3'b000, 7'b0, 64'h5, 64'h5, 64'h40, 0,
                    mk(1, 64'h5, 64'h5, 4'b0110, 1, 1, 0)));
    q.push_back(mkv(1, 7'b1100011, 3'b100, 7'b0, 64'h8, 64'h9, 64'h40, 0,
                    mk(1, 64'h8, 64'h9, 4'b0111, 1, 0, 0)));
    q.push_back(mkv(1, 7'b1100011, 3'b101, 7'b0, 64'h8, 64'h9, 64'h40, 0,
                    mk(1, 64'h8, 64'h9, 4'b0111, 1, 1, 0)));
    q.push_back(mkv(1, 7'b1100011, 3'b110, 7'b0, 64'h8, 64'h9, 64'h40, 0,
                    mk(1, 64'h8, 64'h9, 4'b1000, 1, 0, 0)));
    q.push_back(mkv(1, 7'b0010111, 3'b000, 7'b0, 64'h77, 64'h88, 64'h2000, 64'h1000,
                    mk(1, 64'h1000, 64'h2000, 4'b0010, 0, 0, 0)));
    q.push_back(mkv(1, 7'b0110111, 3'b000, 7'b0, 64'h77, 64'h88, 64'h1234_5000, 64'h1000,
                    mk(1, 64'h0, 64'h1234_5000, 4'b0010, 0, 0, 0)));
    q.push_back(mkv(1, 7'b1111111, 3'b000, 7'b0, 64'h11, 64'h22, 64'h33, 64'h44,
                    mk(1, 64'h11, 64'h22, 4'b1111, 0, 0, 1)));
    q.push_back(mkv(0, 7'b1111111, 3'b000, 7'b0, 64'h11, 64'h22, 64'h33, 64'h44, RST));
    foreach (q[i]) begin
      drive(q[i]); sb.push_back(q[i].e);
      @(posedge clk); #1;
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        $display("FAIL branch_upper[%0d]: got %h expected %h", i, got, exp); n_fail++;
      end
    end
    drive(mkv(1, 7'b1100011, 3'b010, 7'b0, 64'h1, 64'h2, 0, 0, RST));
    @(posedge clk); #1;
    n_tests++;
    if ({ex_valid, illegal} !== 2'b11) begin
      $display("FAIL branch_f3_illegal: ev/ill=%b%b expected 11", ex_valid, illegal);
      n_fail++;
    end
  endtask

  task automatic test_stall_flush_reset();
    out_t got, held;
    held = mk(1, 64'h11, 64'h22, 4'b0010, 0, 0, 0);
    drive(mkv(1, 7'b0110011, 3'b000, 7'b0000000, 64'h11, 64'h22, 0, 0, held));
    @(posedge clk); #1;
    got = sample(); n_tests++;
    if (got !== held) begin
      $display("FAIL stall_load: got %h expected %h", got, held); n_fail++;
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mkv(1, 7'b1100011, 3'b111, 7'b0, 64'(k + 100), 64'(k + 200), 64'h8, 64'h4, RST));
      @(posedge clk); #1;
      got = sample(); n_tests++;
      if (got !== held) begin
        $display("FAIL stall_hold[%0d]: got %h expected %h", k, got, held); n_fail++;
      end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    got = sample(); n_tests++;
    if (got !== RST) begin
      $display("FAIL stall_flush: got %h expected %h", got, RST); n_fail++;
    end
    stall = 1'b0; flush = 1'b0;
    drive(mkv(1, 7'b0010111, 3'b0, 7'b0, 64'h5, 64'h6, 64'h10, 64'h3000,
              mk(1, 64'h3000, 64'h10, 4'b0010, 0, 0, 0)));
    @(posedge clk); #1;
    // Reset between edges while stalled must clear immediately
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    got = sample(); n_tests++;
    if (got !== RST) begin
      $display("FAIL async_reset_midstall: got %h expected %h", got, RST); n_fail++;
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    held = mk(1, 64'h3000, 64'h10, 4'b0010, 0, 0, 0);
    drive(mkv(1, 7'b0010111, 3'b0, 7'b0, 64'h5, 64'h6, 64'h10, 64'h3000, held));
    @(posedge clk); #1;
    got = sample(); n_tests++;
    if (got !== held) begin
      $display("FAIL first_capture_after_reset: got %h expected %h", got, held); n_fail++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    got = sample(); n_tests++;
    if (got !== RST) begin
      $display("FAIL flush_alone: got %h expected %h", got, RST); n_fail++;
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch_upper();
    test_stall_flush_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
